// File: rtl/audio_dac_serializer.sv
// rtl/audio_dac_serializer.sv - stereo sample serializer to codec DAC (I2S, or left-justified with AUD_DAC_LEFT_JUSTIFIED_EN)
module audio_dac_serializer #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int SLOT_BITS     = 32,
  parameter int BCLK_DIV      = 6
) (
  input  logic                     AUDIO_CLK,
  input  logic                     reset,
  input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
  input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
  input  logic                     sample_valid,
  output logic                     frame_req,
  output logic                     AUD_BCLK,
  output logic                     AUD_DACLRCK,
  output logic                     AUD_DACDAT,
  output logic                     overrun,
  output logic [7:0]               underrun_cnt
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BIT_W = $clog2(2 * SLOT_BITS);
`ifdef AUD_DAC_LEFT_JUSTIFIED_EN
  localparam int DATA_OFS = 0;
`else
  localparam int DATA_OFS = 1;
`endif
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] K_FIRST  = BIT_W'(DATA_OFS);
  localparam logic [BIT_W-1:0] DEPTH    = BIT_W'(AUD_BIT_DEPTH);

  logic [DIV_W-1:0]         div_cnt, div_nxt;
  logic [BIT_W-1:0]         bit_cnt, bit_nxt, k_nxt, k_ofs;
  logic                     fall_evt, frame_load, right_nxt, data_slot, take;
  logic                     pending;
  logic [AUD_BIT_DEPTH-1:0] hold_l, hold_r, l_shift, r_shift, load_l, load_r;

  always_comb begin
    fall_evt   = (div_cnt == DIV_LAST);
    div_nxt    = fall_evt ? '0 : div_cnt + 1'b1;
    bit_nxt    = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
    frame_load = fall_evt && (bit_cnt == BIT_LAST);
    right_nxt  = (bit_nxt >= SLOT);
    k_nxt      = right_nxt ? bit_nxt - SLOT : bit_nxt;
    // In I2S mode k=0 wraps to all-ones here and so falls outside the data window.
    k_ofs      = k_nxt - K_FIRST;
    data_slot  = (k_ofs < DEPTH);
    take       = frame_load && pending;
    load_l     = pending ? hold_l : '0;
    load_r     = pending ? hold_r : '0;
  end

  always_ff @(posedge AUDIO_CLK or posedge reset) begin
    if (reset) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      AUD_BCLK     <= 1'b0;
      AUD_DACLRCK  <= 1'b0;
      AUD_DACDAT   <= 1'b0;
      frame_req    <= 1'b0;
      overrun      <= 1'b0;
      underrun_cnt <= '0;
      pending      <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      l_shift      <= '0;
      r_shift      <= '0;
    end else begin
      div_cnt   <= div_nxt;
      AUD_BCLK  <= (div_nxt >= DIV_HALF);
      frame_req <= take;
      // A write landing on the load cycle loses nothing: the load took the old sample.
      overrun   <= sample_valid && pending && !take;
      if (sample_valid) begin
        hold_l  <= lsound_in;
        hold_r  <= rsound_in;
        pending <= 1'b1;
      end else if (take) begin
        pending <= 1'b0;
      end
      if (fall_evt) begin
        bit_cnt     <= bit_nxt;
        AUD_DACLRCK <= right_nxt;
        if (frame_load) begin
          r_shift <= load_r;
          if (data_slot) begin
            AUD_DACDAT <= load_l[AUD_BIT_DEPTH-1];
            l_shift    <= load_l << 1;
          end else begin
            AUD_DACDAT <= 1'b0;
            l_shift    <= load_l;
          end
          if (!pending && underrun_cnt != 8'hFF)
            underrun_cnt <= underrun_cnt + 8'd1;
        end else if (data_slot) begin
          if (right_nxt) begin
            AUD_DACDAT <= r_shift[AUD_BIT_DEPTH-1];
            r_shift    <= r_shift << 1;
          end else begin
            AUD_DACDAT <= l_shift[AUD_BIT_DEPTH-1];
            l_shift    <= l_shift << 1;
          end
        end else begin
          AUD_DACDAT <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb/tb_audio_dac_serializer.sv - directed bench for audio_dac_serializer (BCLK_DIV=4, 256-clock frames)
module tb_audio_dac_serializer;

`ifdef AUD_DAC_LEFT_JUSTIFIED_EN
  localparam int OFS = 0;
`else
  localparam int OFS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] lsound_in, rsound_in;
  logic        sample_valid;
  logic        frame_req, bclk, lrck, dat, overrun;
  logic [7:0]  underrun_cnt;

  int tests = 0;
  int fails = 0;

  audio_dac_serializer #(.AUD_BIT_DEPTH(24), .SLOT_BITS(32), .BCLK_DIV(4)) dut (
    .AUDIO_CLK(clk), .reset(reset), .lsound_in(lsound_in), .rsound_in(rsound_in),
    .sample_valid(sample_valid), .frame_req(frame_req), .AUD_BCLK(bclk),
    .AUD_DACLRCK(lrck), .AUD_DACDAT(dat), .overrun(overrun), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one 256-clock frame starting just after a frame-load edge; the
  // frame_req reported is the one from the load that ends this frame.
  task automatic run_frame(input int va1, input logic [23:0] l1, input logic [23:0] r1,
                           input int va2, input logic [23:0] l2, input logic [23:0] r2,
                           output logic [23:0] lw, output logic [23:0] rw,
                           output int pad, output int fr, output int ov,
                           output int brise, output int lrise, output logic dend);
    logic pb, pl;
    lw = '0; rw = '0; pad = 0; fr = 0; ov = 0; brise = -1; lrise = -1;
    pb = bclk; pl = lrck;
    for (int i = 1; i <= 256; i++) begin
      if (i == va1) begin
        sample_valid = 1'b1; lsound_in = l1; rsound_in = r1;
      end else if (i == va2) begin
        sample_valid = 1'b1; lsound_in = l2; rsound_in = r2;
      end
      tick();
      sample_valid = 1'b0;
      if (frame_req) fr++;
      if (overrun) ov++;
      if (bclk && !pb && brise < 0) brise = i;
      if (lrck && !pl && lrise < 0) lrise = i;
      pb = bclk; pl = lrck;
      if (i % 4 == 0 && i < 256) begin
        int b, k;
        b = i / 4;
        k = b % 32;
        if (k >= OFS && k < OFS + 24) begin
          if (b >= 32) rw = {rw[22:0], dat};
          else         lw = {lw[22:0], dat};
        end else if (dat) begin
          pad++;
        end
      end
    end
    dend = dat;
  endtask

  logic [23:0] lw, rw;
  int pad, fr, ov, br, lr, padsum;
  logic de;

  initial begin
    reset = 1'b1; sample_valid = 1'b0; lsound_in = '0; rsound_in = '0;
    repeat (10) tick();
    chk("rst_outs", {26'd0, frame_req, bclk, lrck, dat, overrun, 1'b0}, 32'd0);
    chk("rst_underrun", 32'(underrun_cnt), 32'd0);
    reset = 1'b0;

    // three silent frames
    run_frame(-1, 0, 0, -1, 0, 0, lw, rw, pad, fr, ov, br, lr, de);
    chk("f0_bclk_rise", br, 2);
    chk("f0_lrck_rise", lr, 128);
    chk("f0_data", {8'd0, lw | rw}, 0);
    chk("f0_lrck_end", 32'(lrck), 0);
    run_frame(-1, 0, 0, -1, 0, 0, lw, rw, pad, fr, ov, br, lr, de);
    chk("f1_pad", pad, 0);
    run_frame(-1, 0, 0, -1, 0, 0, lw, rw, pad, fr, ov, br, lr, de);
    chk("f2_data", {8'd0, lw | rw}, 0);
    chk("f2_fr", fr, 0);
    chk("underrun_3", 32'(underrun_cnt), 3);

    // single sample
    run_frame(10, 24'hA5A5A5, 24'h5A5A5A, -1, 0, 0, lw, rw, pad, fr, ov, br, lr, de);
    chk("f3_fr", fr, 1);
    chk("f3_ov", ov, 0);
    chk("f3_underrun", 32'(underrun_cnt), 3);

    // A5/5A goes out; two writes in this frame -> overrun
    run_frame(20, 24'h000001, 24'h000002, 40, 24'h800000, 24'h000003, lw, rw, pad, fr, ov, br, lr, de);
    chk("f4_left", 32'(lw), 32'hA5A5A5);
    chk("f4_right", 32'(rw), 32'h5A5A5A);
    chk("f4_pad", pad, 0);
    chk("f4_ov", ov, 1);
    chk("f4_fr", fr, 1);

    // later write wins; then a write coincident with the load edge
    run_frame(100, 24'h111111, 24'h222222, 256, 24'h123456, 24'h654321, lw, rw, pad, fr, ov, br, lr, de);
    chk("f5_left", 32'(lw), 32'h800000);
    chk("f5_right", 32'(rw), 32'h000003);
    chk("f5_ov", ov, 0);
    chk("f5_fr", fr, 1);

    run_frame(-1, 0, 0, -1, 0, 0, lw, rw, pad, fr, ov, br, lr, de);
    chk("f6_left_old", 32'(lw), 32'h111111);
    chk("f6_right_old", 32'(rw), 32'h222222);
    chk("f6_fr_pending", fr, 1);
    chk("f6_underrun", 32'(underrun_cnt), 3);

    run_frame(10, 24'hC00001, 24'h400003, -1, 0, 0, lw, rw, pad, fr, ov, br, lr, de);
    chk("f7_left_new", 32'(lw), 32'h123456);
    chk("f7_right_new", 32'(rw), 32'h654321);
    chk("f7_bit0_dat", 32'(de), 32'(OFS == 0));
    chk("f7_bit0_lrck", 32'(lrck), 0);

    run_frame(-1, 0, 0, -1, 0, 0, lw, rw, pad, fr, ov, br, lr, de);
    chk("f8_left", 32'(lw), 32'hC00001);
    chk("f8_right", 32'(rw), 32'h400003);
    chk("f8_pad", pad, 0);
    chk("f8_underrun", 32'(underrun_cnt), 4);

    // saturation
    padsum = 0;
    for (int f = 0; f < 255; f++) begin
      run_frame(-1, 0, 0, -1, 0, 0, lw, rw, pad, fr, ov, br, lr, de);
      padsum += pad + int'(lw != 0) + int'(rw != 0);
    end
    chk("sat_silence", padsum, 0);
    chk("underrun_sat", 32'(underrun_cnt), 255);

    // reset in the middle of a data-carrying left slot
    run_frame(10, 24'hFFFFFF, 24'hFFFFFF, -1, 0, 0, lw, rw, pad, fr, ov, br, lr, de);
    chk("pre_rst_fr", fr, 1);
    repeat (42) tick();
    chk("pre_rst_dat", 32'(dat), 1);
    chk("pre_rst_bclk", 32'(bclk), 1);
    reset = 1'b1;
    #1;
    chk("midrst_outs", {26'd0, frame_req, bclk, lrck, dat, overrun, 1'b0}, 32'd0);
    chk("midrst_underrun", 32'(underrun_cnt), 0);
    repeat (3) tick();
    reset = 1'b0;
    run_frame(-1, 0, 0, -1, 0, 0, lw, rw, pad, fr, ov, br, lr, de);
    chk("post_rst_data", {8'd0, lw | rw}, 0);
    chk("post_rst_bclk", br, 2);
    chk("post_rst_lrck", lr, 128);
    chk("post_rst_underrun", 32'(underrun_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
